// File: rtl/acq_sequencer_pkg.sv
// Shared encodings for the acquisition sequencer: FSM states, command bits, status layout.
package acq_sequencer_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_UPLOAD  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam int CMD_START = 0;
   localparam int CMD_ABORT = 1;
   localparam int CMD_CONT  = 2;

   localparam int STAT_GRP_LSB   = 0;
   localparam int STAT_GRP_W     = 12;
   localparam int STAT_ERR_BIT   = 12;
   localparam int STAT_STATE_LSB = 13;

   localparam logic [STAT_GRP_W-1:0] GRP_MAX = '1;

   typedef struct packed {
      logic [2:0]            state;
      logic                  err_timeout;
      logic [STAT_GRP_W-1:0] group_count;
   } status_t;

   function automatic logic [STAT_GRP_W-1:0] grp_inc(input logic [STAT_GRP_W-1:0] g);
      return (g == GRP_MAX) ? g : g + 1'b1;
   endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Host/pipeline-facing signal bundle of the acquisition sequencer.
interface acq_sequencer_if #(
   parameter int CNT_W = 16
);
   logic [15:0]      cmd_i;
   logic [CNT_W-1:0] n_acc_i;
   logic             trigger_start_i;
   logic             pulse_done_i;
   logic             upload_done_i;
   logic             capture_en_o;
   logic             upload_en_o;
   logic             is_first_pls_o;
   logic [CNT_W-1:0] pulse_count_o;
   logic             cfg_lock_o;
   logic             busy_o;
   logic [15:0]      status_o;

   modport master (
      output cmd_i, n_acc_i, trigger_start_i, pulse_done_i, upload_done_i,
      input  capture_en_o, upload_en_o, is_first_pls_o, pulse_count_o, cfg_lock_o, busy_o, status_o
   );

   modport slave (
      input  cmd_i, n_acc_i, trigger_start_i, pulse_done_i, upload_done_i,
      output capture_en_o, upload_en_o, is_first_pls_o, pulse_count_o, cfg_lock_o, busy_o, status_o
   );
endinterface

// File: rtl/acq_sequencer_pulse_counter.sv
// Per-group pulse counter: latches the effective depth, counts completions,
// flags the first pulse in flight and strobes group_full on the last one.
module acq_pulse_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             clr_i,
   input  logic             arm_cap_i,
   input  logic             pulse_i,
   input  logic             abort_i,
   input  logic [CNT_W-1:0] n_acc_i,
   output logic             group_full_o,
   output logic             first_o,
   output logic [CNT_W-1:0] count_o
);
   logic [CNT_W-1:0] n_eff_q, n_eff_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             first_q, first_d;

   always_comb begin
      n_eff_d      = n_eff_q;
      count_d      = count_q;
      first_d      = first_q;
      group_full_o = pulse_i && (count_q == n_eff_q - 1'b1);
      // a zero depth would never complete, so it is treated as one pulse
      if (load_i) n_eff_d = (n_acc_i == '0) ? CNT_W'(1) : n_acc_i;
      if (clr_i)        count_d = '0;
      else if (pulse_i) count_d = count_q + 1'b1;
      if (abort_i || pulse_i) first_d = 1'b0;
      else if (arm_cap_i)     first_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         n_eff_q <= '0;
         count_q <= '0;
         first_q <= 1'b0;
      end else begin
         n_eff_q <= n_eff_d;
         count_q <= count_d;
         first_q <= first_d;
      end
   end

   assign first_o = first_q;
   assign count_o = count_q;
endmodule

// File: rtl/acq_sequencer.sv
// Acquisition controller FSM: start-edge arm, trigger capture, group upload, continuous repeat.
// Optional arm timeout is built only when ACQ_TIMEOUT_EN is defined.
module acq_sequencer
   import acq_sequencer_pkg::*;
#(
   parameter int              CNT_W     = 16,
   parameter int              TO_W      = 24,
   parameter logic [TO_W-1:0] TO_CYCLES = 24'd10000000
) (
   input logic            clk_i,
   input logic            rst_i,
   acq_sequencer_if.slave bus
);
   logic [2:0]            state_q, state_d;
   logic                  start_prev_q;
   logic [STAT_GRP_W-1:0] grp_q, grp_d;
   logic                  cap_q, cap_d, upl_q, upl_d, busy_q, busy_d;
   logic                  start, abort, cont, start_edge;
   logic                  start_clr, rearm, go_cap, pulse, group_full;
   logic                  timeout_hit, err_q;
   logic                  first;
   logic [CNT_W-1:0]      count;
   logic                  cmd_unused;

   assign start      = bus.cmd_i[CMD_START];
   assign abort      = bus.cmd_i[CMD_ABORT];
   assign cont       = bus.cmd_i[CMD_CONT];
   assign start_edge = start && !start_prev_q;
   assign cmd_unused = ^bus.cmd_i[15:3];
   assign pulse      = (state_q == ST_CAPTURE) && bus.pulse_done_i && !abort;

   always_comb begin
      state_d   = state_q;
      grp_d     = grp_q;
      start_clr = 1'b0;
      rearm     = 1'b0;
      go_cap    = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_edge) begin
               state_d   = ST_ARM;
               start_clr = 1'b1;
               grp_d     = '0;
            end
            ST_ARM: if (bus.trigger_start_i) begin
               state_d = ST_CAPTURE;
               go_cap  = 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
            end
            ST_CAPTURE: if (group_full) state_d = ST_UPLOAD;
            ST_UPLOAD: if (bus.upload_done_i) begin
               grp_d   = grp_inc(grp_q);
               state_d = cont ? ST_ARM : ST_DONE;
               rearm   = cont;
            end
            ST_DONE: if (!start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
      cap_d  = (state_d == ST_CAPTURE);
      upl_d  = (state_d == ST_UPLOAD);
      busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE) || (state_d == ST_UPLOAD);
   end

`ifdef ACQ_TIMEOUT_EN
   logic [TO_W-1:0] to_q, to_d;
   logic            err_d, arm_wait;

   assign arm_wait    = (state_q == ST_ARM) && !abort && !bus.trigger_start_i;
   assign timeout_hit = arm_wait && (to_q == TO_CYCLES - 1'b1);

   always_comb begin
      to_d  = to_q;
      err_d = err_q;
      if (start_clr || rearm) to_d = '0;
      else if (arm_wait)      to_d = to_q + 1'b1;
      // error is sticky across abort so the host can still read it back
      if (start_clr)        err_d = 1'b0;
      else if (timeout_hit) err_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
`else
   logic cfg_unused;
   assign timeout_hit = 1'b0;
   assign err_q       = 1'b0;
   assign cfg_unused  = ^TO_CYCLES;
`endif

   acq_pulse_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (start_clr),
      .clr_i       (start_clr || rearm),
      .arm_cap_i   (go_cap),
      .pulse_i     (pulse),
      .abort_i     (abort),
      .n_acc_i     (bus.n_acc_i),
      .group_full_o(group_full),
      .first_o     (first),
      .count_o     (count)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         grp_q        <= '0;
         cap_q        <= 1'b0;
         upl_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start;
         grp_q        <= grp_d;
         cap_q        <= cap_d;
         upl_q        <= upl_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.capture_en_o   = cap_q;
   assign bus.upload_en_o    = upl_q;
   assign bus.is_first_pls_o = first;
   assign bus.pulse_count_o  = count;
   assign bus.cfg_lock_o     = busy_q;
   assign bus.busy_o         = busy_q;
   assign bus.status_o       = status_t'{state: state_q, err_timeout: err_q, group_count: grp_q};
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed + randomized bench for acq_sequencer with a cycle-level behavioural model.
module tb_acq_sequencer;
   localparam int TO_LIM = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   acq_sequencer_if #(.CNT_W(16)) bus();
   acq_sequencer #(.CNT_W(16), .TO_W(24), .TO_CYCLES(24'd100)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   int vectors = 0, miscompares = 0;
   // model: phase uses the status_o state codes (0 idle,1 arm,2 capture,3 upload,4 done)
   int m_ph, m_cnt, m_grp, m_neff, m_to;
   bit m_first, m_err, m_prev;
   logic [15:0] c;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit s, edge_s;
      s      = bus.cmd_i[0];
      edge_s = s && !m_prev;
      m_prev = s;
      if (bus.cmd_i[1]) begin
         m_ph = 0; m_first = 0;
      end else begin
         case (m_ph)
            0: if (edge_s) begin
               m_ph = 1; m_cnt = 0; m_grp = 0; m_err = 0; m_to = 0;
               m_neff = (bus.n_acc_i == 0) ? 1 : int'(bus.n_acc_i);
            end
            1: if (bus.trigger_start_i) begin
               m_ph = 2; m_first = 1;
            end else begin
`ifdef ACQ_TIMEOUT_EN
               m_to++;
               if (m_to == TO_LIM) begin m_ph = 0; m_err = 1; end
`endif
            end
            2: if (bus.pulse_done_i) begin
               m_cnt++; m_first = 0;
               if (m_cnt == m_neff) m_ph = 3;
            end
            3: if (bus.upload_done_i) begin
               if (m_grp < 4095) m_grp++;
               if (bus.cmd_i[2]) begin m_ph = 1; m_cnt = 0; m_to = 0; end
               else m_ph = 4;
            end
            default: if (!s) m_ph = 0;
         endcase
      end
   endtask

   function automatic logic [63:0] dut_vec();
      return {27'd0, bus.capture_en_o, bus.upload_en_o, bus.is_first_pls_o, bus.cfg_lock_o,
              bus.busy_o, bus.pulse_count_o, bus.status_o};
   endfunction

   function automatic logic [63:0] exp_vec();
      logic act;
      logic [2:0] ph3;
      logic [15:0] cnt16;
      logic [11:0] grp12;
      act   = (m_ph >= 1) && (m_ph <= 3);
      ph3   = 3'(m_ph);
      cnt16 = 16'(m_cnt);
      grp12 = 12'(m_grp);
      return {27'd0, m_ph == 2, m_ph == 3, m_first, act, act, cnt16, ph3, m_err, grp12};
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         model_step();
         #1;
         chk("cycle_outputs", dut_vec(), exp_vec());
      end
   end

   task automatic step(input logic [15:0] cm, input logic [15:0] n, input logic t, input logic p, input logic u);
      bus.cmd_i = cm; bus.n_acc_i = n;
      bus.trigger_start_i = t; bus.pulse_done_i = p; bus.upload_done_i = u;
      @(negedge clk);
   endtask

   function automatic logic [2:0] st();
      return bus.status_o[15:13];
   endfunction

   function automatic logic [11:0] grp();
      return bus.status_o[11:0];
   endfunction

   initial begin
      m_ph = 0; m_cnt = 0; m_grp = 0; m_neff = 1; m_to = 0; m_first = 0; m_err = 0; m_prev = 0;
      bus.cmd_i = '0; bus.n_acc_i = '0;
      bus.trigger_start_i = 0; bus.pulse_done_i = 0; bus.upload_done_i = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", dut_vec(), 64'd0);
      rst = 1'b0;

      // depth 4, single shot
      step(16'd0, 16'd4, 0, 0, 0);
      step(16'd1, 16'd4, 0, 0, 0);
      chk("t1_arm_state", 64'(st()), 64'd1);
      step(16'd1, 16'd4, 0, 0, 0);
      step(16'd1, 16'd4, 1, 0, 0);
      chk("t1_first_flag", 64'(bus.is_first_pls_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         step(16'd1, 16'd4, 0, 1, 0);
         if (i < 3) begin
            chk("t1_capture_held", 64'(bus.capture_en_o), 64'd1);
            step(16'd1, 16'd4, 0, 0, 0);
         end
      end
      chk("t1_upload_en", 64'({bus.capture_en_o, bus.upload_en_o}), 64'd1);
      step(16'd1, 16'd4, 0, 0, 1);
      chk("t1_done_state", 64'(st()), 64'd4);
      chk("t1_pulse_count", 64'(bus.pulse_count_o), 64'd4);
      chk("t1_group_count", 64'(grp()), 64'd1);
      chk("t1_model_grp", 64'(m_grp), 64'd1);
      step(16'd0, 16'd4, 0, 0, 0);
      chk("t1_back_idle", 64'(st()), 64'd0);

      // zero depth behaves as one pulse
      step(16'd1, 16'd0, 0, 0, 0);
      step(16'd1, 16'd0, 1, 0, 0);
      step(16'd1, 16'd0, 0, 1, 0);
      chk("t2_pulse_count", 64'(bus.pulse_count_o), 64'd1);
      chk("t2_upload_en", 64'(bus.upload_en_o), 64'd1);
      step(16'd1, 16'd0, 0, 0, 1);
      step(16'd0, 16'd0, 0, 0, 0);

      // continuous, depth 2, three groups
      step(16'd5, 16'd2, 0, 0, 0);
      for (int g = 0; g < 3; g++) begin
         step(16'd5, 16'd2, 1, 0, 0);
         chk("t3_first_set", 64'(bus.is_first_pls_o), 64'd1);
         step(16'd5, 16'd2, 0, 1, 0);
         chk("t3_first_clr", 64'(bus.is_first_pls_o), 64'd0);
         step(16'd5, 16'd2, 0, 1, 0);
         step(16'd5, 16'd2, 0, 0, 1);
         chk("t3_rearm_state", 64'(st()), 64'd1);
      end
      chk("t3_group_count", 64'(grp()), 64'd3);
      step(16'd2, 16'd2, 0, 0, 0);
      step(16'd0, 16'd2, 0, 0, 0);

      // abort after 2 of 5 pulses, then held START must not restart
      step(16'd1, 16'd5, 0, 0, 0);
      step(16'd1, 16'd5, 1, 0, 0);
      step(16'd1, 16'd5, 0, 1, 0);
      step(16'd1, 16'd5, 0, 1, 0);
      step(16'd3, 16'd5, 0, 0, 0);
      chk("t4_abort_idle", 64'(st()), 64'd0);
      chk("t4_enables_off", 64'({bus.capture_en_o, bus.upload_en_o, bus.busy_o}), 64'd0);
      chk("t4_count_held", 64'(bus.pulse_count_o), 64'd2);
      step(16'd1, 16'd5, 0, 0, 0);
      step(16'd1, 16'd5, 0, 0, 0);
      chk("t4_no_retrigger", 64'(st()), 64'd0);
      step(16'd0, 16'd5, 0, 0, 0);
      step(16'd1, 16'd5, 0, 0, 0);
      chk("t4_restart", 64'(st()), 64'd1);
      step(16'd2, 16'd5, 0, 0, 0);
      step(16'd0, 16'd5, 0, 0, 0);

      // abort beats a coincident trigger in ARM
      step(16'd1, 16'd3, 0, 0, 0);
      step(16'd3, 16'd3, 1, 0, 0);
      chk("t5_abort_wins", 64'({st(), bus.capture_en_o}), 64'd0);
      step(16'd0, 16'd3, 0, 0, 0);

      // long wait in ARM without trigger
      step(16'd1, 16'd3, 0, 0, 0);
      repeat (TO_LIM + 10) step(16'd1, 16'd3, 0, 0, 0);
`ifdef ACQ_TIMEOUT_EN
      chk("t6_timeout_idle", 64'({st(), bus.status_o[12]}), 64'h1);
`else
      chk("t6_arm_waits", 64'({st(), bus.status_o[12]}), 64'h2);
`endif
      step(16'd0, 16'd3, 0, 0, 0);
      step(16'd1, 16'd3, 0, 0, 0);
      chk("t6_err_cleared", 64'({st(), bus.status_o[12]}), 64'h2);
      step(16'd2, 16'd3, 0, 0, 0);
      step(16'd0, 16'd3, 0, 0, 0);

      // group counter saturation
      step(16'd5, 16'd0, 0, 0, 0);
      repeat (4100) begin
         step(16'd5, 16'd0, 1, 0, 0);
         step(16'd5, 16'd0, 0, 1, 0);
         step(16'd5, 16'd0, 0, 0, 1);
      end
      chk("t7_group_sat", 64'(grp()), 64'd4095);
      step(16'd2, 16'd0, 0, 0, 0);
      step(16'd0, 16'd0, 0, 0, 0);

      // random traffic
      c = '0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) c[0] = ~c[0];
         if ($urandom_range(0, 31) == 0) c[2] = ~c[2];
         c[1]    = ($urandom_range(0, 79) == 0);
         c[15:3] = 13'($urandom);
         step(c, 16'($urandom_range(0, 5)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Top-level acquisition controller for the power-spectrum accumulation pipeline. Decodes the host command register, arms on the next trigger, and counts per-pulse spectrum completions until the programmed accumulation depth is reached. It then runs the buffer upload phase and repeats in continuous mode. It drives capture/upload enables, the first-pulse flag, and the config-lock that freezes the SPI register shadow.

Parameters:
CNT_W, 16, width of pulse counter and accumulation-depth input
TO_W, 24, width of arm-timeout counter (used only with ACQ_TIMEOUT_EN)
TO_CYCLES, 24'd10000000, arm-timeout limit in clk_i cycles

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
cmd_i  in  16  host command: bit0 START (level), bit1 ABORT, bit2 CONTINUOUS; other bits ignored
n_acc_i  in  CNT_W  pulses to accumulate per group
trigger_start_i  in  1  one-cycle pulse-start strobe from trigger generator
pulse_done_i  in  1  one-cycle strobe: one pulse's spectrum finished
upload_done_i  in  1  one-cycle strobe: accumulation buffer fully uploaded
capture_en_o  out  1  enables accumulation buffer/pulse processing
upload_en_o  out  1  enables buffer readout
is_first_pls_o  out  1  high while the first pulse of a group is in flight (overwrite, no add)
pulse_count_o  out  CNT_W  pulses completed in current group
cfg_lock_o  out  1  high in every state except IDLE/DONE; blocks register updates
busy_o  out  1  high in ARM, CAPTURE, UPLOAD
status_o  out  16  {state[2:0], err_timeout, group_count[11:0]}

Behaviour:
- All outputs registered. Reset values: every enable/flag is 0, pulse_count_o=0, status_o=0, state=IDLE.
- START edge: cmd_i[0] registered once; a rising edge (0->1) is a start request. A held level does not retrigger.
- n_eff = (n_acc_i==0) ? 1 : n_acc_i. n_eff is latched on leaving IDLE and ignored afterwards.
- States: IDLE, ARM, CAPTURE, UPLOAD, DONE.
- IDLE -> ARM on a start edge. Clears pulse_count, group_count and err_timeout.
- ARM -> CAPTURE on trigger_start_i. In the same edge: capture_en_o=1, is_first_pls_o=1.
- CAPTURE: each pulse_done_i increments pulse_count. is_first_pls_o clears on the cycle after the first pulse_done_i.
- CAPTURE -> UPLOAD on the clock edge where pulse_done_i arrives with pulse_count==n_eff-1. That edge sets pulse_count=n_eff, capture_en_o=0, upload_en_o=1. Latency from final pulse_done_i to upload_en_o is 1 cycle.
- UPLOAD on upload_done_i: upload_en_o=0 and group_count+1 (saturates at 4095).
  - CONTINUOUS=1: go to ARM with pulse_count=0 and the latched n_eff kept.
  - CONTINUOUS=0: go to DONE.
- DONE -> IDLE when cmd_i[0]==0.
- trigger_start_i outside ARM: ignored. pulse_done_i outside CAPTURE: ignored. upload_done_i outside UPLOAD: ignored.
- ABORT (cmd_i[1]=1) has priority over every transition. Next state is IDLE and all enables drop on the next edge. pulse_count_o and group_count are held for readback.
- Coincident trigger_start_i and ABORT in ARM: ABORT wins.
- Coincident pulse_done_i and upload_done_i in CAPTURE: only pulse_done_i is acted on.
- Asynchronous reset mid-operation: immediate return to reset values. No partial upload resumes.
- pulse_count_o never exceeds n_eff.

Optional Feature:
ACQ_TIMEOUT_EN
- Defined: a TO_W-bit counter runs in ARM. When it reaches TO_CYCLES with no trigger, go to IDLE and set err_timeout=1. err_timeout stays set until the next start edge. The counter clears on entering ARM.
- Undefined: no counter is built, ARM waits indefinitely, and err_timeout is tied to 0.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, ARM=1, CAPTURE=2, UPLOAD=3, DONE=4)
  - cmd_i bit-index constants (CMD_START=0, CMD_ABORT=1, CMD_CONT=2)
  - status_o field offsets
- One sub-module: acq_pulse_counter. It owns the CNT_W counter, the n_eff compare and the is_first_pls generation, and emits a group_full strobe. The FSM, edge detect and timeout stay in acq_sequencer.

Test Plan:
- n_acc_i=4, CONTINUOUS=0, START edge, 1 trigger, 4 pulse_done_i -> capture_en_o high through the 4th strobe; upload_en_o=1 one cycle later. After upload_done_i: state DONE, pulse_count_o=4, group_count=1.
- n_acc_i=0 -> one pulse_done_i ends capture; pulse_count_o=1.
- CONTINUOUS=1, n_acc_i=2, 3 full groups -> ARM re-entered 3 times, status_o group_count=3, is_first_pls_o high exactly once per group.
- ABORT during CAPTURE after 2 of 5 pulses -> IDLE next edge, all enables 0, pulse_count_o=2. START held high does not restart; toggling 0->1 restarts.
- START held, then coincident trigger_start_i and ABORT in ARM -> stays IDLE, capture_en_o never asserted.
- With ACQ_TIMEOUT_EN, TO_CYCLES=100, no trigger -> IDLE at cycle 100 with status_o err bit=1. Next START edge clears it.
